// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: BRAM-backed frame playback with start/stop, loop/one-shot and frame divider.
// Optional build macro LEDSEQ_PINGPONG_EN makes loop playback bounce between address 0 and len.
module led_pattern_sequencer #(
   parameter int AW        = 5,
   parameter int LW        = 5,
   parameter int DW        = 24,
   parameter     INIT_FILE = ""
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          start,
   input  logic          stop,
   input  logic          oneshot,
   input  logic [AW-1:0] len,
   input  logic [DW-1:0] div,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [LW-1:0] wr_data,
   output logic [LW-1:0] LEDS,
   output logic          busy,
   output logic          done
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t        stateQ, stateD;
   logic [AW-1:0] pcQ, pcD;
   logic [DW-1:0] cntQ, cntD;
   logic [AW-1:0] lenQ, lenD;
   logic [DW-1:0] divQ, divD;
   logic          oneshotQ, oneshotD;
   logic          rdValidQ, rdValidD;
   logic          lastQ, lastD;
   logic [LW-1:0] ledsQ, ledsD;
   logic          doneQ, doneD;
   logic          atEnd;
   logic          commit;
`ifdef LEDSEQ_PINGPONG_EN
   logic          dirQ, dirD;
`endif

   logic [LW-1:0] mem [0:DEPTH-1];
   logic [LW-1:0] rdDataQ;

   // Initial BRAM contents: all zeros.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   // Read-first BRAM: a same-address write and read in one cycle returns the old word.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rdDataQ <= mem[pcQ];
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         stateQ   <= IDLE;
         pcQ      <= '0;
         cntQ     <= '0;
         lenQ     <= '0;
         divQ     <= '0;
         oneshotQ <= 1'b0;
         rdValidQ <= 1'b0;
         lastQ    <= 1'b0;
         ledsQ    <= '0;
         doneQ    <= 1'b0;
`ifdef LEDSEQ_PINGPONG_EN
         dirQ     <= 1'b0;
`endif
      end else begin
         stateQ   <= stateD;
         pcQ      <= pcD;
         cntQ     <= cntD;
         lenQ     <= lenD;
         divQ     <= divD;
         oneshotQ <= oneshotD;
         rdValidQ <= rdValidD;
         lastQ    <= lastD;
         ledsQ    <= ledsD;
         doneQ    <= doneD;
`ifdef LEDSEQ_PINGPONG_EN
         dirQ     <= dirD;
`endif
      end
   end

   // Next-state logic: capture on start, tick-driven reads and PC advance while playing.
   always_comb begin
      stateD   = stateQ;
      pcD      = pcQ;
      cntD     = cntQ;
      lenD     = lenQ;
      divD     = divQ;
      oneshotD = oneshotQ;
      rdValidD = 1'b0;
      lastD    = 1'b0;
      ledsD    = ledsQ;
      atEnd    = 1'b0;
`ifdef LEDSEQ_PINGPONG_EN
      dirD     = dirQ;
`endif

      // A stop in the same cycle as the read landing discards that frame.
      commit = rdValidQ && !stop;
      if (commit) ledsD = rdDataQ;
      doneD = commit && lastQ;

      case (stateQ)
         IDLE: begin
            if (start && !stop) begin
               stateD   = PLAY;
               pcD      = '0;
               cntD     = '0;
               lenD     = len;
               divD     = div;
               oneshotD = oneshot;
`ifdef LEDSEQ_PINGPONG_EN
               dirD     = 1'b0;
`endif
            end
         end
         PLAY: begin
            if (stop) begin
               stateD = IDLE;
            end else if (start) begin
               pcD      = '0;
               cntD     = '0;
               lenD     = len;
               divD     = div;
               oneshotD = oneshot;
`ifdef LEDSEQ_PINGPONG_EN
               dirD     = 1'b0;
`endif
            end else if (cntQ == '0) begin
               rdValidD = 1'b1;
               cntD     = divQ;
`ifdef LEDSEQ_PINGPONG_EN
               if (lenQ == '0) begin
                  pcD   = '0;
                  atEnd = 1'b1;
               end else if (!dirQ) begin
                  if (pcQ == lenQ) begin
                     pcD  = lenQ - 1'b1;
                     dirD = 1'b1;
                  end else begin
                     pcD  = pcQ + 1'b1;
                  end
               end else if (pcQ == '0) begin
                  pcD   = AW'(1);
                  dirD  = 1'b0;
                  atEnd = 1'b1;
               end else begin
                  pcD   = pcQ - 1'b1;
               end
`else
               atEnd = (pcQ == lenQ);
               pcD   = atEnd ? '0 : pcQ + 1'b1;
`endif
               lastD = oneshotQ && atEnd;
               if (lastD) stateD = IDLE;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         default: stateD = IDLE;
      endcase
   end

   assign LEDS = ledsQ;
   assign busy = (stateQ == PLAY);
   assign done = doneQ;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic checked against a schedule-based reference model.
module tb_led_pattern_sequencer;

   logic        CLK = 1'b0;
   logic        RESET, start, stop, oneshot, wr_en;
   logic [4:0]  len, wr_addr, wr_data;
   logic [23:0] div;
   logic [4:0]  LEDS;
   logic        busy, done;

   int checks = 0;
   int errors = 0;

   led_pattern_sequencer dut (
      .CLK(CLK), .RESET(RESET), .start(start), .stop(stop), .oneshot(oneshot),
      .len(len), .div(div), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .LEDS(LEDS), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rstN, st, sp, os;
      logic [4:0]  ln;
      logic [23:0] dv;
      logic        we;
      logic [4:0]  wa, wd;
      logic [4:0]  expLeds;
      logic        expBusy, expDone;
   } vec_t;

   function automatic vec_t mk(logic rstN, logic st, logic sp, logic os, logic [4:0] ln,
                               logic [23:0] dv, logic we, logic [4:0] wa, logic [4:0] wd,
                               logic [4:0] el, logic eb, logic ed);
      vec_t v;
      v.rstN = rstN; v.st = st; v.sp = sp; v.os = os; v.ln = ln; v.dv = dv;
      v.we = we; v.wa = wa; v.wd = wd; v.expLeds = el; v.expBusy = eb; v.expDone = ed;
      return v;
   endfunction

   // Reference model: playback is a schedule of reads at edges start+1+k*(div+1).
   logic [4:0] mMem [0:31];
   longint     edgeN = 0, mStart = 0;
   logic       mPlaying = 0, mOs = 0, mPendValid = 0, mPendLast = 0, mDone = 0;
   logic [4:0] mPendData = '0, mLeds = '0;
   int         mLen = 0, mDiv = 0;

   function automatic longint lastK();
`ifdef LEDSEQ_PINGPONG_EN
      return (mLen == 0) ? 0 : 2 * mLen;
`else
      return mLen;
`endif
   endfunction

   function automatic int addrOf(longint k);
`ifdef LEDSEQ_PINGPONG_EN
      longint r;
      if (mLen == 0) return 0;
      r = k % (2 * mLen);
      return int'((r <= mLen) ? r : 2 * mLen - r);
`else
      return int'(k % (mLen + 1));
`endif
   endfunction

   task automatic modelEdge();
      longint off, k;
      logic   nDone;
      edgeN++;
      if (!RESET) begin
         mPlaying = 0; mLeds = '0; mDone = 0; mPendValid = 0; mPendLast = 0;
      end else begin
         nDone = 0;
         if (mPendValid && !stop) begin
            mLeds = mPendData;
            nDone = mPendLast;
         end
         mPendValid = 0;
         mPendLast  = 0;
         if (mPlaying && stop) begin
            mPlaying = 0;
         end else if (start && !stop) begin
            mPlaying = 1; mStart = edgeN; mLen = int'(len); mDiv = int'(div); mOs = oneshot;
         end else if (mPlaying) begin
            off = edgeN - mStart - 1;
            if (off % (mDiv + 1) == 0) begin
               k = off / (mDiv + 1);
               mPendValid = 1;
               mPendData  = mMem[addrOf(k)];
               mPendLast  = mOs && (k == lastK());
               if (mPendLast) mPlaying = 0;
            end
         end
         mDone = nDone;
      end
      if (wr_en) mMem[wr_addr] = wr_data;
   endtask

   task automatic applyStimulus(input vec_t v);
      RESET = v.rstN; start = v.st; stop = v.sp; oneshot = v.os; len = v.ln; div = v.dv;
      wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
      @(posedge CLK);
      modelEdge();
      #1;
      checks++;
      if (LEDS !== mLeds || busy !== mPlaying || done !== mDone) begin
         errors++;
         $display("[TB] FAIL model edge %0d: LEDS=%b busy=%b done=%b, model LEDS=%b busy=%b done=%b",
                  edgeN, LEDS, busy, done, mLeds, mPlaying, mDone);
      end
   endtask

   task automatic checkOutput(input string name, input logic [4:0] el, input logic eb, input logic ed);
      checks++;
      if (LEDS !== el || busy !== eb || done !== ed) begin
         errors++;
         $display("[TB] FAIL %s: LEDS=%b busy=%b done=%b, expected LEDS=%b busy=%b done=%b",
                  name, LEDS, busy, done, el, eb, ed);
      end
   endtask

   vec_t       tbl[$];
   logic [4:0] pat [0:3];
   vec_t       idle, rst;

   initial begin
      pat[0] = 5'b00000; pat[1] = 5'b00001; pat[2] = 5'b00010; pat[3] = 5'b00100;
      for (int i = 0; i < 32; i++) mMem[i] = '0;
      idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      applyStimulus(rst);
      checkOutput("reset", 5'b0, 1'b0, 1'b0);
      for (int a = 0; a < 32; a++)
         applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 5'(a), (a < 4) ? pat[a] : 5'b0, 0, 0, 0));

      // loop, len=3, div=0, then stop discarding the in-flight frame
      tbl.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 0, 0));
      // one-shot, len=3, div=0
      tbl.push_back(rst);
      tbl.push_back(mk(1, 1, 0, 1, 3, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0, 1));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0, 0));
      // start and stop together at frame 2
      tbl.push_back(rst);
      tbl.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 3, 0, 0, 0, 0, 5'b00010, 0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 0, 0));
      // write collides with read of MEM[1]; then reset mid-play
      tbl.push_back(rst);
      tbl.push_back(mk(1, 1, 0, 0, 3, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 5'b11111, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vec%0d", i), tbl[i].expLeds, tbl[i].expBusy, tbl[i].expDone);
      end

      // restore MEM[1], then div=3: every frame held 4 cycles, done never asserts
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 1, 5'b00001, 0, 0, 0));
      applyStimulus(mk(1, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0));
      for (int e = 1; e <= 24; e++) begin
         applyStimulus(idle);
         checkOutput($sformatf("div3_e%0d", e), (e < 2) ? 5'b0 : pat[((e - 2) / 4) % 4], 1'b1, 1'b0);
      end

      // len=0: MEM[0] re-read every frame
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0, 5'b10101, 0, 0, 0));
      applyStimulus(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      for (int e = 1; e <= 8; e++) begin
         applyStimulus(idle);
         checkOutput($sformatf("len0_e%0d", e), (e < 2) ? 5'b0 : 5'b10101, 1'b1, 1'b0);
      end

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         vec_t v;
         v = idle;
         v.rstN = ($urandom_range(0, 299) != 0);
         v.st   = ($urandom_range(0, 39) == 0);
         v.sp   = ($urandom_range(0, 69) == 0);
         v.os   = $urandom_range(0, 1);
         v.ln   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) v.ln = 5'($urandom_range(0, 4));
         v.dv   = 24'($urandom_range(0, 3));
         v.we   = ($urandom_range(0, 3) == 0);
         v.wa   = 5'($urandom_range(0, 31));
         v.wd   = 5'($urandom_range(0, 31));
         applyStimulus(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
